// File: rtl/bus_rr_router.sv
// Round-robin shared-bus router: pops one packet per transfer from a pending device,
// then unicasts or broadcasts it with back-pressure wait, timeout drop and address drop.
module bus_rr_router #(
   parameter int         drvrs     = 4,
   parameter int         pckg_sz   = 16,
   parameter logic [7:0] broadcast = 8'hFF,
   parameter int         wait_max  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [drvrs-1:0]           pndng,
   input  logic [drvrs*pckg_sz-1:0]   D_pop,
   input  logic [drvrs-1:0]           full,
   output logic [drvrs-1:0]           pop,
   output logic [drvrs-1:0]           push,
   output logic [pckg_sz-1:0]         D_push,
   output logic                       busy,
   output logic [15:0]                drop_cnt,
   output logic [15:0]                tout_cnt
);

   localparam int gw = (drvrs > 1) ? $clog2(drvrs) : 1;
   localparam int ww = (wait_max > 1) ? $clog2(wait_max + 1) : 1;
   localparam logic [drvrs-1:0] one_hot0  = {{(drvrs-1){1'b0}}, 1'b1};
   localparam logic [gw-1:0]    last_rst  = gw'(drvrs - 1);
   localparam logic [ww-1:0]    wait_last = ww'(wait_max - 1);

   typedef enum logic [2:0] {IDLE, POP, ROUTE, WAIT, PUSH} state_t;

   state_t               state, next_state;
   logic [gw-1:0]        grant, last, next_grant;
   logic [pckg_sz-1:0]   hold, pop_data, d_push_q;
   logic [drvrs-1:0]     mask_q, route_mask;
   logic [ww-1:0]        wait_cnt;
   logic [7:0]           dest_id;
   logic                 route_ok, blocked;

   // Next grant: lowest pending index above last, otherwise lowest pending index overall.
   always_comb begin
      logic found_hi;
      logic [gw-1:0] g_hi, g_lo;
      found_hi = 1'b0;
      g_hi     = '0;
      g_lo     = '0;
      for (int i = drvrs - 1; i >= 0; i--) begin
         if (pndng[i]) begin
            if (gw'(i) > last) begin
               found_hi = 1'b1;
               g_hi     = gw'(i);
            end else begin
               g_lo = gw'(i);
            end
         end
      end
      next_grant = found_hi ? g_hi : g_lo;
   end

   always_comb begin
      pop_data = '0;
      for (int i = 0; i < drvrs; i++) begin
         if (grant == gw'(i)) pop_data = D_pop[i*pckg_sz +: pckg_sz];
      end
   end

   // Destination decode from the held packet; self and out-of-range IDs are not routable.
   always_comb begin
      dest_id    = hold[pckg_sz-1 -: 8];
      route_mask = '0;
      route_ok   = 1'b0;
      if (dest_id == broadcast) begin
         route_mask = ~(one_hot0 << grant);
         route_ok   = 1'b1;
      end else if ((dest_id < 8'(drvrs)) && (dest_id != 8'(grant))) begin
         route_mask = one_hot0 << dest_id;
         route_ok   = 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      blocked    = |(mask_q & full);
      pop        = '0;
      push       = '0;
      busy       = (state != IDLE);
      unique case (state)
         IDLE:  if (|pndng) next_state = POP;
         POP: begin
            pop        = one_hot0 << grant;
            next_state = ROUTE;
         end
         ROUTE: begin
            if (!route_ok)                 next_state = IDLE;
            else if (|(route_mask & full)) next_state = WAIT;
            else                           next_state = PUSH;
         end
         WAIT: begin
            if (!blocked)                  next_state = PUSH;
            else if (wait_cnt == wait_last) next_state = IDLE;
         end
         PUSH: begin
            push       = mask_q;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign D_push = d_push_q;

   // D_push is loaded only on entry to PUSH so it keeps the last pushed packet otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         grant    <= '0;
         last     <= last_rst;
         hold     <= '0;
         mask_q   <= '0;
         wait_cnt <= '0;
         d_push_q <= '0;
         drop_cnt <= '0;
         tout_cnt <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: if (|pndng) grant <= next_grant;
            POP: begin
               hold <= pop_data;
               last <= grant;
            end
            ROUTE: begin
               mask_q   <= route_mask;
               wait_cnt <= '0;
               if (!route_ok && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            end
            WAIT: begin
               if (blocked) begin
                  if (wait_cnt == wait_last) begin
                     if (tout_cnt != 16'hFFFF) tout_cnt <= tout_cnt + 16'd1;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
         if (next_state == PUSH) d_push_q <= hold;
      end
   end

endmodule

// File: tb/tb_bus_rr_router.sv
// Scoreboard bench for bus_rr_router: directed transfers push expected pop/push events
// into queues; a negedge monitor pops and compares whenever the DUT strobes pop or push.
module tb_bus_rr_router;

   localparam int N = 4;
   localparam int W = 16;

   typedef struct {
      logic [N-1:0] mask;
      logic [W-1:0] data;
   } push_t;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   pndng = '0;
   logic [N*W-1:0] D_pop = '0;
   logic [N-1:0]   full = '0;
   logic [N-1:0]   pop, push;
   logic [W-1:0]   D_push;
   logic           busy;
   logic [15:0]    drop_cnt, tout_cnt;

   logic [N-1:0]   expPop[$];
   push_t          expPush[$];
   int             popsLeft[N];
   int             cyc = 0;
   int             popCycle = 0, pushCycle = 0, idleCycle = 0, fallCycle = 0;
   int             checkCount = 0, passCount = 0;

   bus_rr_router #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF), .wait_max(16)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
      .pop(pop), .push(push), .D_push(D_push), .busy(busy),
      .drop_cnt(drop_cnt), .tout_cnt(tout_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Monitor doubles as the device model: each observed pop consumes one queued packet.
   always @(negedge clk) begin
      push_t e;
      logic [N-1:0] ep;
      if (reset) begin
         if ((pop != 0) && (push != 0)) checkOutput("popPushOverlap", {pop, push}, {pop, 4'b0000});
         if (pop != 0) begin
            popCycle = cyc;
            checkOutput("popOneHot", $countones(pop), 1);
            if (expPop.size() == 0) checkOutput("unexpectedPop", pop, 0);
            else begin
               ep = expPop.pop_front();
               checkOutput("popGrant", pop, ep);
            end
            for (int i = 0; i < N; i++) begin
               if (pop[i] && popsLeft[i] > 0) begin
                  popsLeft[i]--;
                  if (popsLeft[i] == 0) pndng[i] = 1'b0;
               end
            end
         end
         if (push != 0) begin
            pushCycle = cyc;
            if (expPush.size() == 0) checkOutput("unexpectedPush", {push, D_push}, 0);
            else begin
               e = expPush.pop_front();
               checkOutput("pushMask", push, e.mask);
               checkOutput("pushData", D_push, e.data);
            end
         end
      end
   end

   task automatic applyStimulus(input int dev, input logic [W-1:0] pkt, input int count);
      D_pop[dev*W +: W] = pkt;
      popsLeft[dev] = count;
      pndng[dev] = 1'b1;
   endtask

   task automatic waitDone(input string name, input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (pndng == 0 && !busy) begin
            done = 1'b1;
            idleCycle = cyc;
         end
      end
      checkOutput(name, done, 1'b1);
   endtask

   task automatic waitPop(input int dev, input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (!pndng[dev]) done = 1'b1;
      end
      checkOutput("popSeen", done, 1'b1);
   endtask

   task automatic checkIdleOutputs(input string name);
      checkOutput({name, "Pop"}, pop, 0);
      checkOutput({name, "Push"}, push, 0);
      checkOutput({name, "Busy"}, busy, 0);
      checkOutput({name, "DPush"}, D_push, 0);
      checkOutput({name, "DropCnt"}, drop_cnt, 0);
      checkOutput({name, "ToutCnt"}, tout_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < N; i++) popsLeft[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      checkIdleOutputs("reset");
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] single unicast dev1 -> dev3");
      expPop.push_back(4'b0010);
      expPush.push_back('{4'b1000, 16'h03AB});
      applyStimulus(1, 16'h03AB, 1);
      waitDone("unicastDone", 40);
      checkOutput("unicastLatency", pushCycle - popCycle, 2);
      checkOutput("unicastDropCnt", drop_cnt, 0);
      checkOutput("unicastToutCnt", tout_cnt, 0);

      $display("[TB] round robin over all devices");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      expPop.push_back(4'b0001); expPush.push_back('{4'b0010, 16'h0100});
      expPop.push_back(4'b0010); expPush.push_back('{4'b0100, 16'h0211});
      expPop.push_back(4'b0100); expPush.push_back('{4'b1000, 16'h0322});
      expPop.push_back(4'b1000); expPush.push_back('{4'b0001, 16'h0033});
      expPop.push_back(4'b0001); expPush.push_back('{4'b0010, 16'h0100});
      applyStimulus(0, 16'h0100, 2);
      applyStimulus(1, 16'h0211, 1);
      applyStimulus(2, 16'h0322, 1);
      applyStimulus(3, 16'h0033, 1);
      waitDone("rrDone", 100);

      $display("[TB] broadcast from dev2");
      expPop.push_back(4'b0100);
      expPush.push_back('{4'b1011, 16'hFF55});
      applyStimulus(2, 16'hFF55, 1);
      waitDone("bcastDone", 40);

      $display("[TB] invalid and self-addressed drops");
      expPop.push_back(4'b0001);
      applyStimulus(0, 16'h0700, 1);
      waitDone("invalidDone", 40);
      expPop.push_back(4'b0001);
      applyStimulus(0, 16'h0011, 1);
      waitDone("selfDone", 40);
      checkOutput("dropCnt", drop_cnt, 2);
      checkOutput("dropToutCnt", tout_cnt, 0);
      checkOutput("dPushHeld", D_push, 16'hFF55);

      $display("[TB] back-pressure released after 5 cycles");
      full[2] = 1'b1;
      expPop.push_back(4'b0001);
      expPush.push_back('{4'b0100, 16'h0201});
      applyStimulus(0, 16'h0201, 1);
      waitPop(0, 20);
      while (cyc < popCycle + 5) @(negedge clk);
      full[2] = 1'b0;
      fallCycle = cyc;
      waitDone("bpDone", 40);
      checkOutput("bpPushCycle", pushCycle - fallCycle, 1);
      checkOutput("bpToutCnt", tout_cnt, 0);

      $display("[TB] back-pressure timeout");
      full[2] = 1'b1;
      expPop.push_back(4'b0001);
      applyStimulus(0, 16'h0201, 1);
      waitDone("toutDone", 60);
      checkOutput("toutCycles", idleCycle - popCycle, 18);
      checkOutput("toutCnt", tout_cnt, 1);
      checkOutput("toutDropCnt", drop_cnt, 2);

      $display("[TB] reset while waiting");
      expPop.push_back(4'b0001);
      applyStimulus(0, 16'h0201, 1);
      waitPop(0, 20);
      while (cyc < popCycle + 4) @(negedge clk);
      checkOutput("waitBusy", busy, 1);
      reset = 1'b0;
      #1;
      checkIdleOutputs("midReset");
      @(negedge clk);
      reset = 1'b1;
      full = '0;
      expPop.push_back(4'b0001); expPush.push_back('{4'b0010, 16'h0102});
      expPop.push_back(4'b1000); expPush.push_back('{4'b0001, 16'h0033});
      applyStimulus(0, 16'h0102, 1);
      applyStimulus(3, 16'h0033, 1);
      waitDone("postResetDone", 60);
      repeat (4) @(negedge clk);

      checkOutput("popQueueEmpty", expPop.size(), 0);
      checkOutput("pushQueueEmpty", expPush.size(), 0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
